bus_master_ctl: RTL and testbench

Parametrised memory-bus master for the microcontroller datapath, successor to the fixed 8-bit output-bus register stage. It takes a one-cycle command from the control unit, selecting a read or one of two write forms. It then drives the registered address/data/RW bus with a req/ack handshake and a bounded wait-state timeout, and returns read data plus done/error status. It sits between the register file/control unit and data memory.

---
 rtl/bus_pkg.sv | 17 +
 rtl/bus_master_ctl.sv | 132 +++++++++++++
 tb/tb_bus_master_ctl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the memory-bus master: controller state encoding
// and the command-select codes presented on i_sel by the control unit.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_NOP    = 2'b00;
  localparam logic [1:0] SEL_RD     = 2'b01;
  localparam logic [1:0] SEL_WR_NUM = 2'b10;
  localparam logic [1:0] SEL_WR_REG = 2'b11;

endpackage

// File: rtl/bus_master_ctl.sv
// Memory-bus master. Accepts a one-cycle command in IDLE, drives a
// registered address/data/rw bus with o_req until i_ack or a bounded
// wait-state timeout, then pulses o_done (success) or o_err (timeout).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_start, i_sel      command strobe and select (NOP/READ/WRITE forms)
//   i_rx, i_ry, i_num   operands, sampled when the command is accepted
//   o_salida_datos      write data (0 outside REQ)
//   o_direccion_datos   address    (0 outside REQ)
//   o_rw                1 = write, 0 = read (0 outside REQ)
//   o_req, i_ack        request/acknowledge handshake
//   i_mem_rdata         read data, valid with i_ack
//   o_rdata             last successfully read data
//   o_busy, o_done, o_err  status; done/err are one-cycle pulses
module bus_master_ctl
  import bus_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [1:0]        i_sel,
  input  logic [DATA_W-1:0] i_rx,
  input  logic [DATA_W-1:0] i_ry,
  input  logic [DATA_W-1:0] i_num,
  output logic [DATA_W-1:0] o_salida_datos,
  output logic [ADDR_W-1:0] o_direccion_datos,
  output logic              o_rw,
  output logic              o_req,
  input  logic              i_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t              state, state_next;
  logic [CNT_W-1:0]    wait_cnt;
  logic                timeout_hit;
  logic [ADDR_W-1:0]   issue_addr;
  logic [DATA_W-1:0]   issue_data;
  logic                issue_rw;

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Bus values for the command currently on the inputs.
  always_comb begin
    issue_addr = '0;
    issue_data = '0;
    issue_rw   = 1'b0;
    case (i_sel)
      SEL_RD: begin
        issue_addr = i_ry[ADDR_W-1:0];
      end
      SEL_WR_NUM: begin
        issue_addr = i_rx[ADDR_W-1:0];
        issue_data = i_num;
        issue_rw   = 1'b1;
      end
      SEL_WR_REG: begin
        issue_addr = i_rx[ADDR_W-1:0];
        issue_data = i_ry;
        issue_rw   = 1'b1;
      end
      default: ;
    endcase
  end

  // Ack is tested before timeout so a coinciding ack wins.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_start) state_next = (i_sel == SEL_NOP) ? DONE : REQ;
      end
      REQ: begin
        if (i_ack)            state_next = DONE;
        else if (timeout_hit) state_next = ERR;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from state_next so they line up with the state
  // they describe. The bus registers double as the operand latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      o_salida_datos    <= '0;
      o_direccion_datos <= '0;
      o_rw              <= 1'b0;
      o_req             <= 1'b0;
      o_rdata           <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_err             <= 1'b0;
    end else begin
      state  <= state_next;
      o_req  <= (state_next == REQ);
      o_busy <= (state_next != IDLE);
      o_done <= (state_next == DONE);
      o_err  <= (state_next == ERR);

      // Only counts while staying in REQ, so it tops out at TIMEOUT-1.
      if (state == REQ && state_next == REQ) wait_cnt <= wait_cnt + 1'b1;
      else                                   wait_cnt <= '0;

      if (state == IDLE && state_next == REQ) begin
        o_direccion_datos <= issue_addr;
        o_salida_datos    <= issue_data;
        o_rw              <= issue_rw;
      end else if (state_next != REQ) begin
        o_direccion_datos <= '0;
        o_salida_datos    <= '0;
        o_rw              <= 1'b0;
      end

      if (state == REQ && i_ack && !o_rw) o_rdata <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_bus_master_ctl.sv
// Directed bench for bus_master_ctl (DATA_W=8, ADDR_W=8, TIMEOUT=15).
module tb_bus_master_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [1:0] i_sel;
  logic [7:0] i_rx, i_ry, i_num;
  logic [7:0] o_salida_datos;
  logic [7:0] o_direccion_datos;
  logic       o_rw, o_req, i_ack;
  logic [7:0] i_mem_rdata;
  logic [7:0] o_rdata;
  logic       o_busy, o_done, o_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_master_ctl #(.DATA_W(8), .ADDR_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_sel(i_sel),
    .i_rx(i_rx), .i_ry(i_ry), .i_num(i_num),
    .o_salida_datos(o_salida_datos), .o_direccion_datos(o_direccion_datos),
    .o_rw(o_rw), .o_req(o_req), .i_ack(i_ack), .i_mem_rdata(i_mem_rdata),
    .o_rdata(o_rdata), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_sel = 2'b00; i_rx = '0; i_ry = '0;
    i_num = '0; i_ack = 1'b0; i_mem_rdata = '0;
    tick(); tick();
    n_cmp++;
    if ({o_salida_datos, o_direccion_datos, o_rw, o_req} !== 18'h0) begin
      n_bad++; $display("FAIL rst_bus got %h/%h/%b/%b want 0", o_salida_datos, o_direccion_datos, o_rw, o_req);
    end
    n_cmp++;
    if ({o_rdata, o_busy, o_done, o_err} !== 11'h0) begin
      n_bad++; $display("FAIL rst_stat got %h/%b/%b/%b want 0", o_rdata, o_busy, o_done, o_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_num();
    i_sel = 2'b10; i_rx = 8'h3C; i_num = 8'hA5; i_ry = 8'h77; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_cmp++;
    if ({o_req, o_busy, o_rw} !== 3'b111) begin
      n_bad++; $display("FAIL wn_req got req=%b busy=%b rw=%b want 111", o_req, o_busy, o_rw);
    end
    n_cmp++;
    if ({o_direccion_datos, o_salida_datos} !== 16'h3CA5) begin
      n_bad++; $display("FAIL wn_bus got %h/%h want 3c/a5", o_direccion_datos, o_salida_datos);
    end
    tick();
    n_cmp++;
    if ({o_req, o_done} !== 2'b10) begin
      n_bad++; $display("FAIL wn_wait got req=%b done=%b want 10", o_req, o_done);
    end
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    n_cmp++;
    if ({o_req, o_done, o_err, o_busy} !== 4'b0101) begin
      n_bad++; $display("FAIL wn_done got req=%b done=%b err=%b busy=%b want 0101", o_req, o_done, o_err, o_busy);
    end
    n_cmp++;
    if ({o_direccion_datos, o_salida_datos, o_rw} !== 17'h0) begin
      n_bad++; $display("FAIL wn_busclr got %h/%h/%b want 0", o_direccion_datos, o_salida_datos, o_rw);
    end
    tick();
    n_cmp++;
    if ({o_done, o_busy} !== 2'b00) begin
      n_bad++; $display("FAIL wn_idle got done=%b busy=%b want 00", o_done, o_busy);
    end
  endtask

  task automatic test_read();
    i_sel = 2'b01; i_ry = 8'h10; i_rx = 8'hEE; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_cmp++;
    if ({o_req, o_rw, o_direccion_datos, o_salida_datos} !== {2'b10, 8'h10, 8'h00}) begin
      n_bad++; $display("FAIL rd_bus got req=%b rw=%b %h/%h want 1 0 10/00", o_req, o_rw, o_direccion_datos, o_salida_datos);
    end
    i_ack = 1'b1; i_mem_rdata = 8'h5A;
    tick();
    i_ack = 1'b0; i_mem_rdata = 8'h00;
    n_cmp++;
    if ({o_done, o_rdata} !== {1'b1, 8'h5A}) begin
      n_bad++; $display("FAIL rd_done got done=%b rdata=%h want 1 5a", o_done, o_rdata);
    end
    tick();
    n_cmp++;
    if ({o_busy, o_rdata} !== {1'b0, 8'h5A}) begin
      n_bad++; $display("FAIL rd_hold got busy=%b rdata=%h want 0 5a", o_busy, o_rdata);
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int err_pulses = 0;
    i_sel = 2'b11; i_rx = 8'hFF; i_ry = 8'h01; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_cmp++;
    if ({o_direccion_datos, o_salida_datos, o_rw} !== {8'hFF, 8'h01, 1'b1}) begin
      n_bad++; $display("FAIL to_bus got %h/%h/%b want ff/01/1", o_direccion_datos, o_salida_datos, o_rw);
    end
    for (int i = 0; i < 40 && !o_err; i++) begin
      if (o_req) req_cycles++;
      tick();
    end
    n_cmp++;
    if (req_cycles != 15 || o_err !== 1'b1 || o_req !== 1'b0) begin
      n_bad++; $display("FAIL to_len got req_cycles=%0d err=%b req=%b want 15 1 0", req_cycles, o_err, o_req);
    end
    if (o_err) err_pulses++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_err) err_pulses++;
    end
    n_cmp++;
    if (err_pulses != 1 || o_busy !== 1'b0 || o_rdata !== 8'h5A) begin
      n_bad++; $display("FAIL to_after got pulses=%0d busy=%b rdata=%h want 1 0 5a", err_pulses, o_busy, o_rdata);
    end
  endtask

  task automatic test_nop_and_ignore();
    i_sel = 2'b00; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_cmp++;
    if ({o_done, o_req, o_busy} !== 3'b101) begin
      n_bad++; $display("FAIL nop_done got done=%b req=%b busy=%b want 101", o_done, o_req, o_busy);
    end
    tick();
    n_cmp++;
    if ({o_done, o_req, o_busy} !== 3'b000) begin
      n_bad++; $display("FAIL nop_idle got done=%b req=%b busy=%b want 000", o_done, o_req, o_busy);
    end
    i_sel = 2'b10; i_rx = 8'h22; i_num = 8'h33; i_start = 1'b1;
    tick();
    i_sel = 2'b01; i_rx = 8'h44; i_ry = 8'h77; i_num = 8'h99;
    tick();
    tick();
    i_start = 1'b0;
    n_cmp++;
    if ({o_req, o_rw, o_direccion_datos, o_salida_datos} !== {2'b11, 8'h22, 8'h33}) begin
      n_bad++; $display("FAIL ign_bus got req=%b rw=%b %h/%h want 1 1 22/33", o_req, o_rw, o_direccion_datos, o_salida_datos);
    end
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    n_cmp++;
    if (o_done !== 1'b1) begin
      n_bad++; $display("FAIL ign_done got %b want 1", o_done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int flags = 0;
    i_sel = 2'b01; i_ry = 8'h40; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({o_req, o_busy, o_done, o_err, o_rw, o_direccion_datos, o_salida_datos, o_rdata} !== 29'h0) begin
      n_bad++; $display("FAIL rm_clr got req=%b busy=%b done=%b err=%b rw=%b %h/%h rdata=%h want 0", o_req, o_busy, o_done, o_err, o_rw, o_direccion_datos, o_salida_datos, o_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (o_done || o_err || o_req) flags++;
    end
    n_cmp++;
    if (flags != 0) begin
      n_bad++; $display("FAIL rm_quiet got %0d active cycles want 0", flags);
    end
    i_ry = 8'h41; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_ack = 1'b1; i_mem_rdata = 8'hC3;
    tick();
    i_ack = 1'b0;
    n_cmp++;
    if ({o_done, o_rdata} !== {1'b1, 8'hC3}) begin
      n_bad++; $display("FAIL rm_read got done=%b rdata=%h want 1 c3", o_done, o_rdata);
    end
    tick();
  endtask

  task automatic test_ack_at_timeout();
    i_sel = 2'b10; i_rx = 8'h05; i_num = 8'h06; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    n_cmp++;
    if ({o_req, o_err} !== 2'b10) begin
      n_bad++; $display("FAIL at_pre got req=%b err=%b want 10", o_req, o_err);
    end
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    n_cmp++;
    if ({o_done, o_err} !== 2'b10) begin
      n_bad++; $display("FAIL at_win got done=%b err=%b want 10", o_done, o_err);
    end
    tick();
    n_cmp++;
    if ({o_err, o_busy} !== 2'b00) begin
      n_bad++; $display("FAIL at_after got err=%b busy=%b want 00", o_err, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_num();
    test_read();
    test_timeout();
    test_nop_and_ignore();
    test_reset_mid();
    test_ack_at_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
